// File: rtl/traceback_unit_if.sv
// Aligned-pair output stream of the traceback unit (valid/ready).
interface traceback_unit_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic [1:0] out_op;

    modport master (output out_valid, out_a, out_b, out_op, input out_ready);
    modport slave  (input out_valid, out_a, out_b, out_op, output out_ready);
endinterface

// File: rtl/traceback_unit.sv
// Needleman-Wunsch traceback: walks direction RAM from (N,N) to (0,0) and
// streams aligned symbol pairs, end of the alignment first.
module traceback_unit #(
    parameter int N           = 128,
    parameter int BitAddr     = $clog2(N+1),
    parameter int addr_lenght = $clog2(((N+1)*(N+1))-1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [addr_lenght-1:0] dir_addr,
    input  logic [2:0]             dir_rdata,
    output logic [BitAddr:0]       seq_addr_a,
    output logic [BitAddr:0]       seq_addr_b,
    input  logic [2:0]             seq_a,
    input  logic [2:0]             seq_b,
    traceback_unit_if.master       ob,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [BitAddr+1:0]     len
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_EMIT, S_FIN} state_e;
    typedef enum logic [1:0] {OP_DIAG = 2'b00, OP_UP = 2'b01, OP_LEFT = 2'b10} op_e;

    localparam logic [2:0]             GAP        = 3'b111;
    localparam logic [BitAddr:0]       IDX_N      = (BitAddr+1)'(N);
    localparam logic [BitAddr:0]       IDX_ONE    = (BitAddr+1)'(1);
    localparam logic [BitAddr+1:0]     LEN_ONE    = (BitAddr+2)'(1);
    localparam logic [addr_lenght-1:0] ADDR_LAST  = addr_lenght'((N+1)*(N+1)-1);
    localparam logic [addr_lenght-1:0] STEP_DIAG  = addr_lenght'(N+2);
    localparam logic [addr_lenght-1:0] STEP_UP    = addr_lenght'(N+1);
    localparam logic [addr_lenght-1:0] STEP_LEFT  = addr_lenght'(1);

    state_e                 r_state, w_next;
    op_e                    r_op, w_op;
    logic [BitAddr:0]       r_i, r_j, w_ni, w_nj;
    logic [addr_lenght-1:0] r_addr, w_step;
    logic [2:0]             r_a, r_b;
    logic [BitAddr+1:0]     r_len;
    logic                   r_busy, r_done, r_err;
    logic                   w_bad, w_hs, w_last;

    assign w_hs   = (r_state == S_EMIT) && ob.out_ready;
    assign w_last = (w_ni == '0) && (w_nj == '0);

    // Boundary rows/columns override the stored symbol; interior ties go diag.
    always_comb begin
        w_op  = OP_DIAG;
        w_bad = 1'b0;
        if (r_j == '0)        w_op = OP_UP;
        else if (r_i == '0)   w_op = OP_LEFT;
        else if (dir_rdata[0]) w_op = OP_DIAG;
        else if (dir_rdata[1]) w_op = OP_UP;
        else if (dir_rdata[2]) w_op = OP_LEFT;
        else                   w_bad = 1'b1;
    end

    always_comb begin
        w_ni   = r_i;
        w_nj   = r_j;
        w_step = STEP_LEFT;
        case (r_op)
            OP_DIAG: begin w_ni = r_i - IDX_ONE; w_nj = r_j - IDX_ONE; w_step = STEP_DIAG; end
            OP_UP:   begin w_ni = r_i - IDX_ONE; w_step = STEP_UP; end
            default: begin w_nj = r_j - IDX_ONE; w_step = STEP_LEFT; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ADDR;
            S_ADDR:  w_next = S_DATA;
            S_DATA:  w_next = w_bad ? S_FIN : S_EMIT;
            S_EMIT:  if (w_hs) w_next = w_last ? S_FIN : S_ADDR;
            S_FIN:   if (!start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i    <= '0;
            r_j    <= '0;
            r_addr <= '0;
            r_op   <= OP_DIAG;
            r_a    <= '0;
            r_b    <= '0;
            r_len  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_i    <= IDX_N;
                    r_j    <= IDX_N;
                    r_addr <= ADDR_LAST;
                    r_len  <= '0;
                    r_busy <= 1'b1;
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                end
                S_DATA: if (w_bad) begin
                    r_err  <= 1'b1;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_op <= w_op;
                    r_a  <= (w_op == OP_LEFT) ? GAP : seq_a;
                    r_b  <= (w_op == OP_UP)   ? GAP : seq_b;
                end
                // Indices and address move only on an accepted pair.
                S_EMIT: if (w_hs) begin
                    r_len  <= r_len + LEN_ONE;
                    r_i    <= w_ni;
                    r_j    <= w_nj;
                    r_addr <= r_addr - w_step;
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dir_addr     = r_addr;
    assign seq_addr_a   = r_i;
    assign seq_addr_b   = r_j;
    assign ob.out_valid = (r_state == S_EMIT);
    assign ob.out_a     = r_a;
    assign ob.out_b     = r_b;
    assign ob.out_op    = r_op;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign len          = r_len;
endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit (N=4): expected pairs queued per walk,
// a negedge monitor pops and compares every accepted pair.
module tb_traceback_unit;
    localparam int N  = 4;
    localparam int BA = $clog2(N+1);
    localparam int AL = $clog2(((N+1)*(N+1))-1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AL-1:0] dir_addr;
    logic [2:0]    dir_rdata, seq_a, seq_b;
    logic [BA:0]   seq_addr_a, seq_addr_b;
    logic          busy, done, err;
    logic [BA+1:0] len;

    traceback_unit_if ob();

    traceback_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dir_addr(dir_addr), .dir_rdata(dir_rdata),
        .seq_addr_a(seq_addr_a), .seq_addr_b(seq_addr_b),
        .seq_a(seq_a), .seq_b(seq_b),
        .ob(ob),
        .busy(busy), .done(done), .err(err), .len(len)
    );

    logic [2:0] dir_mem [0:(N+1)*(N+1)-1];
    logic [2:0] rom_a [0:N];
    logic [2:0] rom_b [0:N];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dir_rdata <= dir_mem[dir_addr];
        seq_a     <= rom_a[seq_addr_a];
        seq_b     <= rom_b[seq_addr_b];
    end

    typedef struct {
        logic [1:0]    op;
        logic [2:0]    a;
        logic [2:0]    b;
        logic [AL-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ob.out_valid && ob.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pair", 32'(ob.out_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pair_op",   32'(ob.out_op), 32'(e.op));
                chk("pair_a",    32'(ob.out_a),  32'(e.a));
                chk("pair_b",    32'(ob.out_b),  32'(e.b));
                chk("pair_addr", 32'(dir_addr),  32'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int op, input int a, input int b, input int addr);
        exp_t e;
        e.op = 2'(op); e.a = 3'(a); e.b = 3'(b); e.addr = AL'(addr);
        sb.push_back(e);
    endtask

    task automatic fill_dir(input logic [2:0] v);
        for (int k = 0; k < (N+1)*(N+1); k++) dir_mem[k] = v;
    endtask

    task automatic push_all_diag();
        push(0, 4, 3, 24); push(0, 3, 4, 18); push(0, 2, 6, 12); push(0, 1, 5, 6);
    endtask

    task automatic wait_valid(input string name);
        logic got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (ob.out_valid) got = 1'b1;
            else tick();
        end
        chk({name, "_valid_timeout"}, 32'(got), 32'(1));
    endtask

    task automatic finish_walk(input string name, input int exp_len, input int exp_err);
        logic got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            tick();
            if (done) got = 1'b1;
        end
        chk({name, "_done_timeout"}, 32'(got), 32'(1));
        chk({name, "_len"},   32'(len),       32'(exp_len));
        chk({name, "_err"},   32'(err),       32'(exp_err));
        chk({name, "_busy"},  32'(busy),      32'(0));
        chk({name, "_drain"}, 32'(sb.size()), 32'(0));
        repeat (3) tick();
        chk({name, "_hold_done"}, 32'(done), 32'(1));
        chk({name, "_no_retrig"}, 32'(busy), 32'(0));
        start = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rom_a[0] = 3'd0; rom_a[1] = 3'd1; rom_a[2] = 3'd2; rom_a[3] = 3'd3; rom_a[4] = 3'd4;
        rom_b[0] = 3'd0; rom_b[1] = 3'd5; rom_b[2] = 3'd6; rom_b[3] = 3'd4; rom_b[4] = 3'd3;
        fill_dir(3'b001);
        ob.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(ob.out_valid), 32'(0));
        chk("rst_busy",  32'(busy),         32'(0));
        chk("rst_done",  32'(done),         32'(0));
        chk("rst_err",   32'(err),          32'(0));
        chk("rst_len",   32'(len),          32'(0));
        chk("rst_addr",  32'(dir_addr),     32'(0));
        chk("rst_out_a", 32'(ob.out_a),     32'(0));
        chk("rst_op",    32'(ob.out_op),    32'(0));
        rst = 1'b1;
        tick();

        // all diagonal
        push_all_diag();
        start = 1'b1;
        finish_walk("diag", 4, 0);
        chk("diag_addr_end", 32'(dir_addr), 32'(0));

        // all left: four left steps then forced up along j==0
        fill_dir(3'b100);
        push(2, 7, 3, 24); push(2, 7, 4, 23); push(2, 7, 6, 22); push(2, 7, 5, 21);
        push(1, 4, 7, 20); push(1, 3, 7, 15); push(1, 2, 7, 10); push(1, 1, 7, 5);
        start = 1'b1;
        finish_walk("left", 8, 0);

        // tie at (4,4) resolves to diag
        fill_dir(3'b001);
        dir_mem[24] = 3'b111;
        push_all_diag();
        start = 1'b1;
        finish_walk("tie", 4, 0);

        // backpressure on pair 2
        fill_dir(3'b001);
        push_all_diag();
        ob.out_ready = 1'b0;
        start = 1'b1;
        wait_valid("bp_p1");
        ob.out_ready = 1'b1;
        tick();
        ob.out_ready = 1'b0;
        wait_valid("bp_p2");
        repeat (5) begin
            chk("bp_valid", 32'(ob.out_valid), 32'(1));
            chk("bp_a",     32'(ob.out_a),     32'(3));
            chk("bp_b",     32'(ob.out_b),     32'(4));
            chk("bp_addr",  32'(dir_addr),     32'(18));
            tick();
        end
        ob.out_ready = 1'b1;
        finish_walk("bp", 4, 0);

        // invalid symbol at (3,3)
        dir_mem[18] = 3'b000;
        push(0, 4, 3, 24);
        start = 1'b1;
        finish_walk("bad", 1, 1);
        chk("bad_no_valid", 32'(ob.out_valid), 32'(0));
        dir_mem[18] = 3'b001;

        // reset during EMIT of pair 2, then restart from (N,N)
        push(0, 4, 3, 24);
        ob.out_ready = 1'b0;
        start = 1'b1;
        wait_valid("rst_p1");
        ob.out_ready = 1'b1;
        tick();
        ob.out_ready = 1'b0;
        wait_valid("rst_p2");
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ob.out_valid), 32'(0));
        chk("mid_rst_busy",  32'(busy),         32'(0));
        chk("mid_rst_len",   32'(len),          32'(0));
        chk("mid_rst_addr",  32'(dir_addr),     32'(0));
        chk("mid_rst_out_a", 32'(ob.out_a),     32'(0));
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        ob.out_ready = 1'b1;
        tick();
        push_all_diag();
        start = 1'b1;
        finish_walk("restart", 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/traceback_unit.md
# traceback_unit

Downstream stage of the Needleman-Wunsch fill datapath. Once the score/direction matrix is complete (`end_filling`), this block walks the stored direction symbols from cell (N,N) back to (0,0). It reads the direction RAM and both sequence ROMs, and streams one aligned pair per step over a valid/ready handshake. The pairs come out in reverse order, end of the alignment first.

## Interface
Parameters:
- `N`, 128, sequence length.
- `BitAddr`, `$clog2(N+1)`, row/column index width minus one. Indices are `[BitAddr:0]`.
- `addr_lenght`, `$clog2(((N+1)*(N+1))-1)`, matrix RAM address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level or pulse, connected to `end_filling`. Sampled only in IDLE.
- `dir_addr`  out  `addr_lenght`  direction RAM read address, row-major `i*(N+1)+j`.
- `dir_rdata`  in  3  stored symbol, valid 1 cycle after `dir_addr`. Encoding: bit0 = diag, bit1 = up, bit2 = left.
- `seq_addr_a`, `seq_addr_b`  out  `BitAddr+1`  sequence ROM addresses, equal to current i and j. ROM index k holds symbol k, for 1..N.
- `seq_a`, `seq_b`  in  3  ROM data, valid 1 cycle after the address.
- `out_valid`  out  1  output pair valid.
- `out_ready`  in  1  consumer accepts the pair.
- `out_a`, `out_b`  out  3  aligned symbols. Gap code is 3'b111.
- `out_op`  out  2  step type: 00 = diag, 01 = up (a vs gap), 10 = left (gap vs b).
- `busy`  out  1  walk in progress.
- `done`  out  1  walk finished. Held until the next accepted `start`.
- `err`  out  1  walk aborted because of an invalid symbol. Held with `done`.
- `len`  out  `BitAddr+2`  number of pairs emitted, maximum 2N.

## Operation
Registered state:
- Indices `i`, `j`.
- Address register `addr`, updated incrementally; no multiplier.
- FSM with states IDLE, ADDR, DATA, EMIT, FIN.

State transitions:
- **IDLE:** on `start`, load i = j = N, `addr` = (N+1)*(N+1)-1, `len` = 0; clear `done` and `err`; set `busy`; go to ADDR.
- **ADDR:** drive `dir_addr` = `addr`, `seq_addr_a` = i, `seq_addr_b` = j. Go to DATA.
- **DATA:** decode the step. Boundary rules override the stored symbol.
  - j==0: forced up.
  - i==0: forced left.
  - Otherwise priority is diag > up > left, so ties resolve to diag.
  - If the interior symbol is 3'b000: set `err` and `done`, clear `busy`, go to FIN without emitting.
  - Otherwise register `out_a`, `out_b` and `out_op`, then go to EMIT:
    - diag: `out_a` = `seq_a`, `out_b` = `seq_b`.
    - up: `out_a` = `seq_a`, `out_b` = 3'b111.
    - left: `out_a` = 3'b111, `out_b` = `seq_b`.
- **EMIT:** `out_valid` = 1; all outputs stable until `out_ready`. On handshake:
  - `len` += 1.
  - Index update: diag decrements i and j, and `addr` -= N+2. Up decrements i, and `addr` -= N+1. Left decrements j, and `addr` -= 1.
  - If the new (i,j) is (0,0): set `done`, clear `busy`, go to FIN. Otherwise go to ADDR.
- **FIN:** wait for `start` deasserted, then go to IDLE.
  - `done`, `err` and `len` keep their values.
  - A `start` that stays high through the end does not retrigger the walk.

General rules:
- The walk always terminates within 2N steps, because each step decrements i+j by at least 1.
- `start` is ignored outside IDLE.

## Timing
- Reset values: `out_valid`, `busy`, `done`, `err` = 0. `out_a`, `out_b`, `out_op`, `len`, `dir_addr`, `seq_addr_*` = 0. State = IDLE.
- Reset asserted mid-walk aborts immediately. There is no resume; the next `start` restarts from (N,N).
- Per-step latency is 3 cycles (ADDR, DATA, EMIT) with `out_ready` held high. First `out_valid` appears 3 cycles after `start` is sampled.
- `done` rises in the cycle after the final handshake.
- Backpressure: while `out_valid && !out_ready`, no register changes.
- The address and index registers update only on handshake. Addresses never underflow: the (0,0) step is never issued.

## Test plan
- **All-diag, N=4:** all-diag matrix, `out_ready`=1 → `dir_addr` sequence 24, 18, 12, 6. Four pairs with `out_op`=00 and `out_a`/`out_b` = ROM[4..1]. `len`=4, `done`=1, `err`=0.
- **All-left, N=4:** every cell holds 3'b100 → four left steps at addresses 24, 23, 22, 21. Then four forced up steps at j=0 (addresses 20, 15, 10, 5). `len`=8, with gaps on the correct side.
- **Tie resolution:** cell (4,4) holds 3'b111, the rest diag → first `out_op`=00.
- **Backpressure:** `out_ready` low for 5 cycles on pair 2 → `out_valid` stays 1. Outputs and `dir_addr` stay stable. Pair 2 is emitted exactly once.
- **Invalid symbol:** 3'b000 at (3,3) after one diag step → `err`=1, `done`=1, `len`=1, no further `out_valid`.
- **Reset mid-walk:** assert `rst` low during EMIT of pair 2 → all outputs 0 asynchronously. A new `start` begins again at `dir_addr`=24.
